mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ex_valid  in  1  ALU stage presents a valid instruction result.
REQ-004 ex_ready  out  1  mem_stage accepts the presented result this cycle.
REQ-005 alu_result  in  64  ALU result; the memory address for loads and stores.
REQ-006 store_data  in  64  ReadData2 value to store.
REQ-007 mem_read, mem_write, reg_write, set_flags  in  1 each  control bits travelling with the result.
REQ-008 rd  in  5  destination register index.
REQ-009 negative, zero, overflow, carry_out  in  1 each  ALU flags.
REQ-010 dmem_req  out  1  data-memory request, held until acknowledged.
REQ-011 dmem_we  out  1  request is a write.
REQ-012 dmem_addr  out  64  request address.
REQ-013 dmem_wdata  out  64  write data.
REQ-014 dmem_ack  in  1  memory completes the request this cycle.
REQ-015 dmem_rdata  in  64  load data, valid when dmem_ack=1.
REQ-016 wb_valid  out  1  one-cycle writeback strobe.
REQ-017 wb_reg_write  out  1  writeback is to the register file.
REQ-018 wb_rd  out  5  destination index.
REQ-019 wb_data  out  64  load data or ALU result.
REQ-020 wb_err  out  1  misaligned access; no memory request was issued.
REQ-021 flags  out  4  architectural NZVC register as {N,Z,V,C}.

Function
REQ-022 FSM states: IDLE, MEM_WAIT, WB.
REQ-023 ex_ready shall be 1 only in IDLE; a transfer occurs when ex_valid=1 and ex_ready=1.
REQ-024 On transfer, all inputs shall be captured into internal registers; the inputs are not sampled again until the next transfer.
REQ-025 Non-memory op (mem_read=0 and mem_write=0): IDLE->WB; wb_valid=1 in the cycle after the transfer; wb_data = captured alu_result.
REQ-026 Memory op with alu_result[2:0]=0: IDLE->MEM_WAIT; dmem_req=1 starting the cycle after the transfer.
REQ-027 In MEM_WAIT, dmem_addr, dmem_we (=mem_write) and dmem_wdata shall be held stable until dmem_ack.
REQ-028 In MEM_WAIT with dmem_ack=1: dmem_rdata is captured, dmem_req drops the next cycle, and the FSM moves to WB.
REQ-029 Minimum memory-op latency: transfer -> wb_valid is 2 cycles when dmem_ack arrives in the first request cycle.
REQ-030 Loads: wb_data = captured dmem_rdata; wb_reg_write = captured reg_write.
REQ-031 Stores: wb_reg_write=0; wb_valid still pulses so the retire count stays exact.
REQ-032 Misaligned memory op (alu_result[2:0]!=0): no dmem_req; IDLE->WB; wb_err=1 and wb_reg_write=0 with the wb_valid pulse.
REQ-033 mem_read=1 and mem_write=1 together shall be treated as a store.
REQ-034 WB lasts exactly one cycle, then returns to IDLE; wb_* outputs are 0 outside WB.
REQ-035 flags shall update to {negative,zero,overflow,carry_out} on the transfer cycle edge when set_flags=1, independent of the FSM path.
REQ-036 dmem_ack outside MEM_WAIT shall be ignored.

Reset
REQ-037 Reset shall force: FSM to IDLE; ex_ready=1; dmem_req=0; dmem_we=0; dmem_addr=0; dmem_wdata=0; wb_valid=0; wb_err=0; wb_reg_write=0; wb_rd=0; wb_data=0; flags=4'b0000.
REQ-038 Reset asserted during MEM_WAIT shall abandon the request: dmem_req=0 the next cycle, and no writeback.
REQ-039 Reset has priority over a simultaneous transfer or dmem_ack.

Structure
REQ-040 Package mem_stage_pkg: state enum (IDLE, MEM_WAIT, WB), DATA_W=64, REG_IDX_W=5, ALIGN_BITS=3.
REQ-041 One sub-module, flag_register: a 4-bit register with load enable and synchronous reset, instantiated once.

Verification
REQ-042 Add, set_flags=1, alu_result=0x10, flags N0 Z0 V0 C1 -> wb_valid the next cycle, wb_data=0x10, flags=4'b0001.
REQ-043 Load at addr 0x40, dmem_ack after 3 request cycles with rdata 0xDEAD -> dmem_req high for 3 cycles, wb_data=0xDEAD, ex_ready low throughout.
REQ-044 Store at addr 0x08 with data 0x55, immediate ack -> dmem_we=1, dmem_wdata=0x55, wb_valid=1, wb_reg_write=0.
REQ-045 Load at addr 0x43 -> no dmem_req, wb_err=1, wb_reg_write=0, back in IDLE after 2 cycles.
REQ-046 Reset on the 2nd cycle of MEM_WAIT -> dmem_req=0, no wb_valid, flags=0; the next op completes normally.
REQ-047 ex_valid held high for back-to-back ALU ops -> one op accepted every 2 cycles, with wb_valid pulses in order.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and widths for the memory stage
package mem_stage_pkg;
    localparam int DATA_W     = 64;
    localparam int REG_IDX_W  = 5;
    localparam int ALIGN_BITS = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        WB       = 2'd2
    } state_e;

    function automatic logic is_aligned(input logic [DATA_W-1:0] addr);
        return addr[ALIGN_BITS-1:0] == '0;
    endfunction
endpackage

// File: rtl/flag_register.sv
// rtl/flag_register.sv - architectural NZVC register with load enable
module flag_register (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [3:0] flags_i,
    output logic [3:0] flags_o
);
    logic [3:0] flags_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flags_q <= 4'b0000;
        end else if (load_i) begin
            flags_q <= flags_i;
        end
    end

    assign flags_o = flags_q;
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: data-memory handshake, writeback strobe, NZVC flags
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic [DATA_W-1:0]    store_data,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 reg_write,
    input  logic                 set_flags,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 negative,
    input  logic                 zero,
    input  logic                 overflow,
    input  logic                 carry_out,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DATA_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 wb_err,
    output logic [3:0]           flags
);
    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [REG_IDX_W-1:0]   rd_q, rd_d;
    logic                   we_q, we_d;
    logic                   regw_q, regw_d;
    logic                   err_q, err_d;

    logic transfer;
    logic is_mem;
    logic misaligned;

    assign transfer   = (state_q == IDLE) && ex_valid;
    assign is_mem     = mem_read || mem_write;
    assign misaligned = !is_aligned(alu_result);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            regw_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            regw_q  <= regw_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        rd_d    = rd_q;
        we_d    = we_q;
        regw_d  = regw_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    addr_d  = alu_result;
                    wdata_d = store_data;
                    data_d  = alu_result;
                    rd_d    = rd;
                    // read+write together behaves as a store
                    we_d    = mem_write;
                    err_d   = is_mem && misaligned;
                    regw_d  = reg_write && !mem_write && !(is_mem && misaligned);
                    state_d = (is_mem && !misaligned) ? MEM_WAIT : WB;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    if (!we_q) begin
                        data_d = dmem_rdata;
                    end
                    state_d = WB;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ex_ready     = (state_q == IDLE);
    assign dmem_req     = (state_q == MEM_WAIT);
    assign dmem_we      = (state_q == MEM_WAIT) && we_q;
    assign dmem_addr    = (state_q == MEM_WAIT) ? addr_q  : '0;
    assign dmem_wdata   = (state_q == MEM_WAIT) ? wdata_q : '0;

    assign wb_valid     = (state_q == WB);
    assign wb_reg_write = (state_q == WB) && regw_q;
    assign wb_err       = (state_q == WB) && err_q;
    assign wb_rd        = (state_q == WB) ? rd_q   : '0;
    assign wb_data      = (state_q == WB) ? data_q : '0;

    flag_register u_flag_register (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (transfer && set_flags),
        .flags_i ({negative, zero, overflow, carry_out}),
        .flags_o (flags)
    );
endmodule
